bank_arbiter: RTL and testbench
===============================

Name: bank_arbiter

Overview:
- Upstream front-end for one single-port memory bank.
- Accepts read/write requests from NUM_CORES core ports and picks at most one per cycle by round-robin.
- Drives the bank's addr/data_in/read_enable/write_enable lines and routes the bank's 1-cycle-latency read data back to the requesting core.
- Counts contention cycles for performance monitoring.

Parameters:
- NUM_CORES, 4, number of requesting core ports (2..16).
- ADDR_W, 8, bank address width (equals `REG_SIZE).
- DATA_W, 8, data width (equals `REG_SIZE).
- CNT_W, 16, contention counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CORES  per-core request valid.
- req_we  in  NUM_CORES  per-core request type: 1 = write, 0 = read.
- req_addr  in  NUM_CORES*ADDR_W  packed per-core addresses; core k at [k*ADDR_W +: ADDR_W].
- req_data  in  NUM_CORES*DATA_W  packed per-core write data.
- req_ready  out  NUM_CORES  one-hot grant (combinational); request accepted at the edge where valid&ready.
- resp_valid  out  NUM_CORES  one-hot read-data valid (registered).
- resp_data  out  DATA_W  read data, shared by all cores; meaningful only when some resp_valid bit is 1.
- bank_addr  out  ADDR_W  to bank addr.
- bank_data_in  out  DATA_W  to bank data_in.
- bank_read_enable  out  1  to bank read_enable.
- bank_write_enable  out  1  to bank write_enable.
- bank_data_out  in  DATA_W  from bank data_out; valid the cycle after a read command.
- conflict_cnt  out  CNT_W  number of cycles with 2 or more req_valid bits set.

Behaviour:
- State:
  - last_grant: index register, reset value NUM_CORES-1, so core 0 has first priority.
  - rd_pend: 1 bit, reset 0.
  - rd_core: index register, reset 0.
  - conflict_cnt: reset 0.
- Arbitration (combinational, each cycle):
  - Search req_valid starting at (last_grant+1) mod NUM_CORES, wrapping.
  - The first set bit k is the winner; req_ready = one-hot(k).
  - No valid bits: req_ready = 0.
- Bank command (combinational, same cycle as grant):
  - bank_addr/bank_data_in = winner's req_addr/req_data.
  - bank_write_enable = grant & req_we[k].
  - bank_read_enable = grant & ~req_we[k].
  - No grant: both enables 0; bank_addr/bank_data_in = 0.
- On a grant at a posedge: last_grant <= k. With no grant, last_grant holds.
- Read latency:
  - Read granted in cycle N: rd_pend <= 1 and rd_core <= k.
  - In cycle N+1: resp_valid = one-hot(rd_core) when rd_pend, and resp_data = bank_data_out (combinational pass-through).
  - rd_pend clears the following cycle unless a new read is granted in N+1.
  - Back-to-back reads, one per cycle, are supported at full throughput.
- Writes produce no response. A write in N followed by a read of the same address in N+1 returns the new data.
- Handshake rules:
  - Once req_valid[k] rises, the core holds it and req_we/req_addr/req_data stable until req_ready[k].
  - A core may issue a new request in the cycle after acceptance.
  - The arbiter never grants a core whose req_valid is 0.
- Fairness: any continuously valid requester is granted within NUM_CORES cycles.
- conflict_cnt:
  - Increments each cycle in which popcount(req_valid) >= 2.
  - Saturates at all-ones; no wrap.
- Reset:
  - While reset = 1: req_ready = 0 and bank enables = 0 (forced combinationally).
  - State registers load their reset values at the edge.
  - A read granted in the cycle before reset is dropped: resp_valid is 0 during and after the reset cycle.
  - Counter clears.
- Outputs during reset: req_ready = 0, resp_valid = 0, resp_data = bank_data_out (don't-care), bank_addr = 0, bank_data_in = 0, enables = 0, conflict_cnt = 0.

Decomposition:
- Shared include (SharedInc):
  - `ARB_NUM_CORES
  - `ARB_IDX_SIZE (clog2 of NUM_CORES)
  - `CONFLICT_CNT_SIZE
  - Reuse `REG_SIZE / `REG_RANGE for widths.
- One natural sub-module: rr_picker. Combinational rotate-priority-encoder taking req vector and last index, returning grant one-hot, index and any_grant. It is reusable by future multi-bank crossbars.

Test Plan:
- Single read: after reset, write 8'hA5 to addr 8'h10 from core 2; next cycle core 2 reads 8'h10 -> req_ready=4'b0100 both cycles; resp_valid=4'b0100 one cycle after the read grant; resp_data=8'hA5.
- Round-robin: all 4 cores hold reads continuously from reset -> grants in order core0, 1, 2, 3, 0 on consecutive cycles; conflict_cnt=5 after 5 cycles.
- Mixed back-to-back:
  - Stimulus: core1 writes 8'h3C to addr 8'h20 (cycle N) while core3 waits; core3 reads 8'h20 (cycle N+1).
  - Response: resp_valid=4'b1000 in N+2 with resp_data=8'h3C; no resp_valid in N+1.
- Idle and hold: no requests for 3 cycles -> enables 0, last_grant unchanged; then core0 and core1 request -> core1 granted first if last_grant was 0.
- Reset mid-read: grant core2 read in cycle N, assert reset in N+1 -> resp_valid=0 in N+1 and N+2; conflict_cnt=0; first grant after reset goes to core0.
- Counter saturation: with CNT_W=4, hold 2 requesters for 20 cycles -> conflict_cnt stops at 4'hF.

Source files
------------

// File: rtl/bank_arbiter_pkg.sv
// Shared widths, defaults and the bank command encoding for the bank arbiter.
package bank_arbiter_pkg;

  localparam int REG_SIZE          = 8;
  localparam int ARB_NUM_CORES     = 4;
  localparam int CONFLICT_CNT_SIZE = 16;

  // Command presented to the single-port bank in a given cycle.
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } bank_cmd_e;

endpackage

// File: rtl/bank_arbiter_rr_picker.sv
// Rotating-priority encoder: the search starts one past the last winner and
// wraps, so every active requester is reached within N picks.
module bank_arbiter_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Walk the candidates in rotated order and keep the first active one.
  always_comb begin
    int cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_i) + i) % N;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = IDX_W'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Round-robin front-end for one single-port memory bank: grants one core
// request per cycle, drives the bank command, returns 1-cycle read data to
// the requester and counts cycles with competing requests.
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int NUM_CORES = ARB_NUM_CORES,
  parameter int ADDR_W    = REG_SIZE,
  parameter int DATA_W    = REG_SIZE,
  parameter int CNT_W     = CONFLICT_CNT_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES-1:0]        req_we,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] req_data,
  output logic [NUM_CORES-1:0]        req_ready,
  output logic [NUM_CORES-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [DATA_W-1:0]           bank_data_in,
  output logic                        bank_read_enable,
  output logic                        bank_write_enable,
  input  logic [DATA_W-1:0]           bank_data_out,
  output logic [CNT_W-1:0]            conflict_cnt
);

  localparam int IDX_W = $clog2(NUM_CORES);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0] rd_core_q, rd_core_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic [NUM_CORES-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 grant;
  logic                 multi_req;
  bank_cmd_e            cmd;

  bank_arbiter_rr_picker #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Grant, bank command and next-state logic; reset suppresses any grant.
  always_comb begin
    grant     = pick_any & ~reset;
    cmd       = CMD_IDLE;
    req_ready = '0;
    bank_addr    = '0;
    bank_data_in = '0;
    if (grant) begin
      cmd          = req_we[pick_idx] ? CMD_WRITE : CMD_READ;
      req_ready    = pick_gnt;
      bank_addr    = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      bank_data_in = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    end
    bank_read_enable  = (cmd == CMD_READ);
    bank_write_enable = (cmd == CMD_WRITE);

    // x & (x-1) is non-zero exactly when two or more bits are set.
    multi_req = |(req_valid & (req_valid - NUM_CORES'(1)));

    last_grant_d   = grant ? pick_idx : last_grant_q;
    rd_pend_d      = (cmd == CMD_READ);
    rd_core_d      = (cmd == CMD_READ) ? pick_idx : rd_core_q;
    conflict_cnt_d = (multi_req && conflict_cnt_q != '1) ? conflict_cnt_q + CNT_W'(1)
                                                         : conflict_cnt_q;
  end

  // State registers with synchronous reset.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q   <= IDX_W'(NUM_CORES - 1);
      rd_pend_q      <= 1'b0;
      rd_core_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      rd_pend_q      <= rd_pend_d;
      rd_core_q      <= rd_core_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Read response: the bank data passes straight through one cycle after the
  // read command; a read pending across a reset cycle is discarded.
  always_comb begin
    resp_valid = (rd_pend_q && !reset) ? (NUM_CORES'(1) << rd_core_q) : '0;
    resp_data  = bank_data_out;
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a behavioural 1-cycle-latency bank.
module tb_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_we;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_ready, resp_valid;
  logic [7:0]  resp_data, bank_addr, bank_data_in, bank_data_out;
  logic        bank_read_enable, bank_write_enable;
  logic [15:0] conflict_cnt;

  logic [3:0]  s_ready, s_resp_valid;
  logic [7:0]  s_resp_data, s_addr, s_din;
  logic        s_ren, s_wen;
  logic [3:0]  s_cnt;

  logic [7:0]  mem [256];
  logic [3:0]  exp_rr [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .bank_addr(bank_addr), .bank_data_in(bank_data_in),
    .bank_read_enable(bank_read_enable), .bank_write_enable(bank_write_enable),
    .bank_data_out(bank_data_out), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance sharing the same inputs, for saturation checks.
  bank_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .req_ready(s_ready), .resp_valid(s_resp_valid), .resp_data(s_resp_data),
    .bank_addr(s_addr), .bank_data_in(s_din),
    .bank_read_enable(s_ren), .bank_write_enable(s_wen),
    .bank_data_out(bank_data_out), .conflict_cnt(s_cnt)
  );

  // Bank model: synchronous write, registered read data.
  always @(posedge clk) begin
    if (bank_write_enable) mem[bank_addr] <= bank_data_in;
    if (bank_read_enable)  bank_data_out  <= mem[bank_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_reqs();
    req_valid = 4'hF;
    next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (bank_read_enable !== 1'b0 || bank_write_enable !== 1'b0) begin errors++; $display("FAIL reset_enables got r%b w%b exp 0 0", bank_read_enable, bank_write_enable); end
    checks++; if (bank_addr !== 8'h00 || bank_data_in !== 8'h00) begin errors++; $display("FAIL reset_bank_bus got %h/%h exp 00/00", bank_addr, bank_data_in); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
    req_valid = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    req_valid = 4'b0100; req_we = 4'b0100;
    req_addr[2*8 +: 8] = 8'h10; req_data[2*8 +: 8] = 8'hA5;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sr_write_ready got %b exp 0100", req_ready); end
    checks++; if (bank_write_enable !== 1'b1 || bank_read_enable !== 1'b0) begin errors++; $display("FAIL sr_write_cmd got r%b w%b exp r0 w1", bank_read_enable, bank_write_enable); end
    checks++; if (bank_addr !== 8'h10 || bank_data_in !== 8'hA5) begin errors++; $display("FAIL sr_write_bus got %h/%h exp 10/a5", bank_addr, bank_data_in); end
    next_cycle();
    req_we = 4'b0000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sr_read_ready got %b exp 0100", req_ready); end
    checks++; if (bank_read_enable !== 1'b1 || bank_write_enable !== 1'b0) begin errors++; $display("FAIL sr_read_cmd got r%b w%b exp r1 w0", bank_read_enable, bank_write_enable); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL sr_no_resp_for_write got %b exp 0000", resp_valid); end
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL sr_resp_valid got %b exp 0100", resp_valid); end
    checks++; if (resp_data !== 8'hA5) begin errors++; $display("FAIL sr_resp_data got %h exp a5", resp_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL sr_resp_clears got %b exp 0000", resp_valid); end
  endtask

  task automatic test_round_robin();
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    reset = 1'b1;
    clear_reqs();
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) req_addr[k*8 +: 8] = 8'(k);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== exp_rr[i]) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", i, req_ready, exp_rr[i]); end
      if (i > 0) begin
        checks++; if (resp_valid !== exp_rr[i-1]) begin errors++; $display("FAIL rr_resp_%0d got %b exp %b", i, resp_valid, exp_rr[i-1]); end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (conflict_cnt !== 16'd5) begin errors++; $display("FAIL rr_conflict_cnt got %0d exp 5", conflict_cnt); end
    clear_reqs();
  endtask

  task automatic test_mixed_back_to_back();
    do_reset();
    req_valid = 4'b1010; req_we = 4'b0010;
    req_addr[1*8 +: 8] = 8'h20; req_data[1*8 +: 8] = 8'h3C;
    req_addr[3*8 +: 8] = 8'h20;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mx_write_ready got %b exp 0010", req_ready); end
    checks++; if (bank_write_enable !== 1'b1 || bank_data_in !== 8'h3C) begin errors++; $display("FAIL mx_write_cmd got w%b d%h exp w1 d3c", bank_write_enable, bank_data_in); end
    next_cycle();
    req_valid = 4'b1000; req_we = 4'b0000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mx_read_ready got %b exp 1000", req_ready); end
    checks++; if (bank_read_enable !== 1'b1 || bank_addr !== 8'h20) begin errors++; $display("FAIL mx_read_cmd got r%b a%h exp r1 a20", bank_read_enable, bank_addr); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL mx_no_early_resp got %b exp 0000", resp_valid); end
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (resp_valid !== 4'b1000) begin errors++; $display("FAIL mx_resp_valid got %b exp 1000", resp_valid); end
    checks++; if (resp_data !== 8'h3C) begin errors++; $display("FAIL mx_resp_data got %h exp 3c", resp_data); end
    checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL mx_conflict_cnt got %0d exp 1", conflict_cnt); end
    next_cycle();
  endtask

  task automatic test_idle_hold();
    do_reset();
    req_valid = 4'b0001; req_we = 4'b0001;
    req_addr[0 +: 8] = 8'h30; req_data[0 +: 8] = 8'h55;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ih_first_ready got %b exp 0001", req_ready); end
    next_cycle();
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000 || bank_read_enable !== 1'b0 || bank_write_enable !== 1'b0) begin errors++; $display("FAIL ih_idle_%0d got rdy %b r%b w%b exp 0000 r0 w0", i, req_ready, bank_read_enable, bank_write_enable); end
      checks++; if (bank_addr !== 8'h00) begin errors++; $display("FAIL ih_idle_addr_%0d got %h exp 00", i, bank_addr); end
      next_cycle();
    end
    req_valid = 4'b0011;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ih_core1_first got %b exp 0010", req_ready); end
    next_cycle();
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ih_core0_next got %b exp 0001", req_ready); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req_valid = 4'b0100; req_we = 4'b0000;
    req_addr[2*8 +: 8] = 8'h40;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100 || bank_read_enable !== 1'b1) begin errors++; $display("FAIL rm_read_grant got rdy %b r%b exp 0100 r1", req_ready, bank_read_enable); end
    next_cycle();
    reset = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rm_resp_in_reset got %b exp 0000", resp_valid); end
    checks++; if (req_ready !== 4'b0000 || bank_read_enable !== 1'b0 || bank_write_enable !== 1'b0) begin errors++; $display("FAIL rm_forced_idle got rdy %b r%b w%b exp 0000 r0 w0", req_ready, bank_read_enable, bank_write_enable); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rm_resp_after_reset got %b exp 0000", resp_valid); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL rm_cnt_cleared got %0d exp 0", conflict_cnt); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_core0_first got %b exp 0001", req_ready); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_cnt_saturation();
    do_reset();
    req_valid = 4'b0011; req_we = 4'b0000;
    repeat (14) next_cycle();
    @(negedge clk);
    checks++; if (s_cnt !== 4'hE) begin errors++; $display("FAIL sat_cnt_14 got %h exp e", s_cnt); end
    checks++; if (conflict_cnt !== 16'd14) begin errors++; $display("FAIL wide_cnt_14 got %0d exp 14", conflict_cnt); end
    repeat (6) next_cycle();
    @(negedge clk);
    checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt_20 got %h exp f", s_cnt); end
    checks++; if (conflict_cnt !== 16'd20) begin errors++; $display("FAIL wide_cnt_20 got %0d exp 20", conflict_cnt); end
    next_cycle();
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_mixed_back_to_back();
    test_idle_hold();
    test_reset_mid_read();
    test_cnt_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
